// File: rtl/cell_update_ctrl_pkg.sv
// Shared definitions for the cell update read-modify-write engine:
// default geometry, operation encodings, cell ceiling and FSM states.
package cell_update_ctrl_pkg;

  localparam int ADDR_W_DEF     = 11;
  localparam int DATA_W_DEF     = 4;
  localparam int DEPTH_DEF      = 1070;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF    = 15;

  localparam logic OP_INC = 1'b0;
  localparam logic OP_SET = 1'b1;

  localparam int CELL_MAX = 15;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CHECK    = 4'd1,
    ST_RD_ISSUE = 4'd2,
    ST_RD_WAIT  = 4'd3,
    ST_WR_ISSUE = 4'd4,
    ST_WR_WAIT  = 4'd5,
    ST_WR_GAP   = 4'd6,
    ST_RESP     = 4'd7
  } state_t;

endpackage

// File: rtl/cell_update_ctrl_req_fifo.sv
// Synchronous show-ahead request FIFO; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module req_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;

  always_ff @(posedge clka or posedge rst_n) begin
    if (rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // A push into a full FIFO is only issued alongside a pop, so overwriting the
  // head slot is safe: the head is consumed by the same edge.
  always_ff @(posedge clka) begin
    if (i_push) r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[PTR_W-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

endmodule

// File: rtl/cell_update_ctrl.sv
// Read-modify-write engine in front of the dual-port cell RAM: one queued
// update at a time is read on port A, modified, written on port B, answered.
module cell_update_ctrl
  import cell_update_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_op,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_resp_valid,
  output logic              o_resp_err,
  output logic [DATA_W-1:0] o_resp_old,
  output logic [DATA_W-1:0] o_resp_new,
  output logic              o_ena,
  output logic [ADDR_W-1:0] o_addra,
  input  logic [DATA_W-1:0] i_doa,
  input  logic              i_doa_valid,
  output logic              o_enb,
  output logic              o_web,
  output logic [ADDR_W-1:0] o_addrb,
  output logic [DATA_W-1:0] o_dib,
  input  logic              i_dob_valid
);

  localparam int                REQ_W      = 1 + ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] CELL_MAX_W = DATA_W'(CELL_MAX);
  localparam logic [3:0]        TIMEOUT_W  = 4'(TIMEOUT);

  state_t            r_state;
  logic              r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_wait_cnt;
  logic              r_ena;
  logic [ADDR_W-1:0] r_addra;
  logic              r_enb;
  logic [ADDR_W-1:0] r_addrb;
  logic [DATA_W-1:0] r_dib;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_old;
  logic [DATA_W-1:0] r_resp_new;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [REQ_W-1:0]  w_head;
  logic              w_head_op;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [DATA_W-1:0] w_new_val;
  logic [3:0]        w_cnt_next;
  logic              w_timeout;

  // Ready is held low while reset is asserted; a full FIFO still accepts when
  // the FSM pops in the same cycle.
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;
  assign o_req_ready = !rst_n && (!w_full || w_pop);
  assign w_push      = i_req_valid && o_req_ready;

  req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clka    (clka),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({i_req_op, i_req_addr, i_req_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_op, w_head_addr, w_head_data} = w_head;

  // Increment saturates at the cell ceiling instead of wrapping to zero.
  assign w_new_val  = (r_op == OP_SET) ? r_data :
                      ((i_doa == CELL_MAX_W) ? i_doa : i_doa + 1'b1);
  assign w_cnt_next = (r_wait_cnt == 4'hF) ? r_wait_cnt : r_wait_cnt + 4'd1;
  assign w_timeout  = (w_cnt_next == TIMEOUT_W);

  always_ff @(posedge clka or posedge rst_n) begin
    if (rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_wait_cnt   <= '0;
      r_ena        <= 1'b0;
      r_addra      <= '0;
      r_enb        <= 1'b0;
      r_addrb      <= '0;
      r_dib        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_old   <= '0;
      r_resp_new   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_op    <= w_head_op;
            r_addr  <= w_head_addr;
            r_data  <= w_head_data;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_addr > LAST_ADDR) begin
            r_resp_err   <= 1'b1;
            r_resp_old   <= '0;
            r_resp_new   <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_ena   <= 1'b1;
            r_addra <= r_addr;
            r_state <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          r_ena      <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (i_doa_valid) begin
            r_resp_old <= i_doa;
            r_resp_new <= w_new_val;
            r_enb      <= 1'b1;
            r_addrb    <= r_addr;
            r_dib      <= w_new_val;
            r_state    <= ST_WR_ISSUE;
          end else if (w_timeout) begin
            r_resp_err   <= 1'b1;
            r_resp_old   <= '0;
            r_resp_new   <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_wait_cnt <= w_cnt_next;
          end
        end
        ST_WR_ISSUE: begin
          r_enb      <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= ST_WR_WAIT;
        end
        // An aborted write keeps the computed value in resp_new.
        ST_WR_WAIT: begin
          if (i_dob_valid) begin
            r_state <= ST_WR_GAP;
          end else if (w_timeout) begin
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_wait_cnt <= w_cnt_next;
          end
        end
        ST_WR_GAP: begin
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ena        = r_ena;
  assign o_addra      = r_addra;
  assign o_enb        = r_enb;
  assign o_web        = r_enb;
  assign o_addrb      = r_addrb;
  assign o_dib        = r_dib;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_old   = r_resp_old;
  assign o_resp_new   = r_resp_new;

endmodule

// File: tb/tb_cell_update_ctrl.sv
// Directed bench for cell_update_ctrl with a behavioural dual-port cell RAM
// (3-cycle read latency, 2-cycle write strobe) that can be stubbed silent.
module tb_cell_update_ctrl;

  logic        clka;
  logic        rst_n;
  logic        reqValid;
  logic        reqReady;
  logic        reqOp;
  logic [10:0] reqAddr;
  logic [3:0]  reqData;
  logic        respValid;
  logic        respErr;
  logic [3:0]  respOld;
  logic [3:0]  respNew;
  logic        ena;
  logic [10:0] addra;
  logic [3:0]  doa;
  logic        doaValid;
  logic        enb;
  logic        web;
  logic [10:0] addrb;
  logic [3:0]  dib;
  logic        dobValid;

  cell_update_ctrl dut (
    .clka         (clka),
    .rst_n        (rst_n),
    .i_req_valid  (reqValid),
    .o_req_ready  (reqReady),
    .i_req_op     (reqOp),
    .i_req_addr   (reqAddr),
    .i_req_data   (reqData),
    .o_resp_valid (respValid),
    .o_resp_err   (respErr),
    .o_resp_old   (respOld),
    .o_resp_new   (respNew),
    .o_ena        (ena),
    .o_addra      (addra),
    .i_doa        (doa),
    .i_doa_valid  (doaValid),
    .o_enb        (enb),
    .o_web        (web),
    .o_addrb      (addrb),
    .o_dib        (dib),
    .i_dob_valid  (dobValid)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  logic [3:0]  ramMem [0:2047];
  logic [2:0]  rdPipe;
  logic [1:0]  wrPipe;
  logic [10:0] rdAddrQ;
  logic        stubRead;
  logic        stubWrite;
  logic        preloadEn;
  logic [10:0] preloadAddr;
  logic [3:0]  preloadData;

  always @(posedge clka or posedge rst_n) begin
    if (rst_n) begin
      rdPipe <= '0;
      wrPipe <= '0;
    end else begin
      rdPipe <= {rdPipe[1:0], ena && !stubRead};
      wrPipe <= {wrPipe[0], enb && web && !stubWrite};
    end
  end

  always @(posedge clka) begin
    if (ena) rdAddrQ <= addra;
    if (enb && web) ramMem[addrb] <= dib;
    if (preloadEn) ramMem[preloadAddr] <= preloadData;
  end

  assign doaValid = rdPipe[2];
  assign doa      = ramMem[rdAddrQ];
  assign dobValid = wrPipe[1];

  typedef struct {
    logic       err;
    logic [3:0] oldV;
    logic [3:0] newV;
  } respRec_t;

  respRec_t respQ[$];
  int cycleCount    = 0;
  int enaCount      = 0;
  int enbCount      = 0;
  int lastEnaCycle  = 0;
  int lastRespCycle = 0;

  always @(negedge clka) begin
    cycleCount = cycleCount + 1;
    if (ena) begin
      enaCount     = enaCount + 1;
      lastEnaCycle = cycleCount;
    end
    if (enb) enbCount = enbCount + 1;
    if (respValid) begin
      respQ.push_back('{err: respErr, oldV: respOld, newV: respNew});
      lastRespCycle = cycleCount;
    end
  end

  int errorCount = 0;
  int checkCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (actual !== expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [10:0] addr,
                               input logic [3:0] data);
    int guard = 0;
    @(negedge clka);
    reqValid = 1'b1;
    reqOp    = op;
    reqAddr  = addr;
    reqData  = data;
    while (!reqReady && guard < 200) begin
      @(negedge clka);
      guard++;
    end
    if (!reqReady) checkOutput("push_ready", reqReady, 1);
    @(posedge clka);
    #1 reqValid = 1'b0;
  endtask

  task automatic preload(input logic [10:0] addr, input logic [3:0] data);
    @(negedge clka);
    preloadEn   = 1'b1;
    preloadAddr = addr;
    preloadData = data;
    @(negedge clka);
    preloadEn = 1'b0;
  endtask

  task automatic getResponse(output respRec_t r);
    int guard = 0;
    while (respQ.size() == 0 && guard < 100) begin
      @(negedge clka);
      guard++;
    end
    if (respQ.size() == 0) begin
      checkOutput("resp_arrive", respValid, 1);
      r = '{err: 1'b0, oldV: 4'd0, newV: 4'd0};
    end else begin
      r = respQ.pop_front();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    respRec_t r;
    int enaBase;
    int enbBase;
    int guard;

    rst_n       = 1'b1;
    reqValid    = 1'b0;
    reqOp       = 1'b0;
    reqAddr     = '0;
    reqData     = '0;
    stubRead    = 1'b0;
    stubWrite   = 1'b0;
    preloadEn   = 1'b0;
    preloadAddr = '0;
    preloadData = '0;

    // Reset state
    repeat (3) @(negedge clka);
    checkOutput("rst_ready", reqReady, 0);
    checkOutput("rst_resp_valid", respValid, 0);
    checkOutput("rst_ena", ena, 0);
    checkOutput("rst_enb", enb, 0);
    rst_n = 1'b0;
    #1 checkOutput("rel_ready", reqReady, 1);

    // Increment 3 -> 4 with exactly one read and one write
    preload(11'h005, 4'd3);
    enaBase = enaCount;
    enbBase = enbCount;
    applyStimulus(1'b0, 11'h005, 4'd0);
    getResponse(r);
    checkOutput("inc_err", r.err, 0);
    checkOutput("inc_old", r.oldV, 3);
    checkOutput("inc_new", r.newV, 4);
    checkOutput("inc_ram", ramMem[5], 4);
    checkOutput("inc_ena_pulses", enaCount - enaBase, 1);
    checkOutput("inc_enb_pulses", enbCount - enbBase, 1);

    // Saturation at 15
    preload(11'h005, 4'd15);
    applyStimulus(1'b0, 11'h005, 4'd0);
    getResponse(r);
    checkOutput("sat_old", r.oldV, 15);
    checkOutput("sat_new", r.newV, 15);
    checkOutput("sat_ram", ramMem[5], 15);

    // Last valid address
    applyStimulus(1'b1, 11'd1069, 4'd9);
    getResponse(r);
    checkOutput("set_last_err", r.err, 0);
    checkOutput("set_last_new", r.newV, 9);
    checkOutput("set_last_ram", ramMem[1069], 9);

    // First invalid address: error, no RAM traffic
    enaBase = enaCount;
    enbBase = enbCount;
    applyStimulus(1'b1, 11'd1070, 4'd9);
    getResponse(r);
    checkOutput("oor_err", r.err, 1);
    checkOutput("oor_old", r.oldV, 0);
    checkOutput("oor_new", r.newV, 0);
    checkOutput("oor_ena_pulses", enaCount - enaBase, 0);
    checkOutput("oor_enb_pulses", enbCount - enbBase, 0);

    // Burst of six increments: FIFO fills after the fifth accept
    preload(11'h010, 4'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 11'h010, 4'd0);
      if (i == 4) checkOutput("burst_ready_low", reqReady, 0);
    end
    for (int i = 0; i < 6; i++) begin
      getResponse(r);
      checkOutput($sformatf("burst_old_%0d", i), r.oldV, i);
      checkOutput($sformatf("burst_new_%0d", i), r.newV, i + 1);
    end
    checkOutput("burst_ram", ramMem[16], 6);

    // Read timeout: 15 wait cycles after the read issue cycle
    stubRead = 1'b1;
    applyStimulus(1'b0, 11'h020, 4'd0);
    getResponse(r);
    checkOutput("rd_to_err", r.err, 1);
    checkOutput("rd_to_latency", lastRespCycle - lastEnaCycle, 16);
    stubRead = 1'b0;

    // Write timeout keeps the computed value
    preload(11'h021, 4'd7);
    stubWrite = 1'b1;
    applyStimulus(1'b0, 11'h021, 4'd0);
    getResponse(r);
    checkOutput("wr_to_err", r.err, 1);
    checkOutput("wr_to_old", r.oldV, 7);
    checkOutput("wr_to_new", r.newV, 8);
    stubWrite = 1'b0;

    // Engine back in service after a timeout
    applyStimulus(1'b0, 11'h021, 4'd0);
    getResponse(r);
    checkOutput("post_to_err", r.err, 0);
    checkOutput("post_to_old", r.oldV, 8);
    checkOutput("post_to_new", r.newV, 9);

    // Reset while waiting for the write strobe
    stubWrite = 1'b1;
    enbBase   = enbCount;
    applyStimulus(1'b1, 11'h030, 4'd5);
    guard = 0;
    while (enbCount == enbBase && guard < 50) begin
      @(negedge clka);
      guard++;
    end
    checkOutput("mid_rst_enb_seen", enbCount - enbBase, 1);
    @(posedge clka);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("mid_rst_enb", enb, 0);
    checkOutput("mid_rst_ena", ena, 0);
    checkOutput("mid_rst_resp_valid", respValid, 0);
    repeat (2) @(negedge clka);
    rst_n     = 1'b0;
    stubWrite = 1'b0;
    #1 checkOutput("mid_rst_ready", reqReady, 1);
    repeat (20) @(negedge clka);
    checkOutput("mid_rst_no_resp", respQ.size(), 0);
    applyStimulus(1'b1, 11'h030, 4'd6);
    getResponse(r);
    checkOutput("after_rst_err", r.err, 0);
    checkOutput("after_rst_new", r.newV, 6);
    checkOutput("after_rst_ram", ramMem[48], 6);

    repeat (5) @(negedge clka);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
